// File: rtl/regfile_scheduler_if.sv
// Debug/host access port of the register-file scheduler: level request held
// until a one-cycle ack, read data valid alongside the ack.
interface regfile_scheduler_if #(
    parameter int WORD = 64,
    parameter int AW   = 5
);
    logic            req;
    logic            we;
    logic [AW-1:0]   addr;
    logic [WORD-1:0] wdata;
    logic            ack;
    logic [WORD-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/regfile_scheduler.sv
// Clears the register memory after reset, then shares its write port and read
// port 1 between the CPU datapath and the debug port, with starvation relief.
//
// state   | meaning
// INIT    | clearing register clr_idx, CPU stalled, debug ignored
// IDLE    | CPU owns the ports, debug waits for a free cycle or starvation
// DBG_SVC | debug owns read port 1 (and write port if dbg.we), CPU stalled
// DBG_ACK | dbg.ack pulse, starvation count cleared, CPU owns the ports
module regfile_scheduler #(
    parameter int  WORD       = 64,
    parameter int  NREGS      = 32,
    parameter int  STARVE_MAX = 4,
    localparam int AW         = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_reg_write,
    input  logic [AW-1:0]      cpu_write_reg,
    input  logic [WORD-1:0]    cpu_write_data,
    input  logic [AW-1:0]      cpu_read_reg1,
    output logic [WORD-1:0]    cpu_read_data1,
    output logic               cpu_stall,
    output logic               init_done,
    regfile_scheduler_if.slave dbg,
    output logic               rf_we,
    output logic [AW-1:0]      rf_waddr,
    output logic [WORD-1:0]    rf_wdata,
    output logic [AW-1:0]      rf_raddr1,
    input  logic [WORD-1:0]    rf_rdata1
);

    localparam int            SW         = $clog2(STARVE_MAX + 1);
    localparam logic [AW-1:0] XZR        = AW'(NREGS - 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        DBG_SVC,
        DBG_ACK
    } state_t;

    state_t        state;
    logic [AW-1:0] clr_idx;
    logic [SW-1:0] starve_cnt;
    logic          starve_full;

    assign starve_full = (starve_cnt == STARVE_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            clr_idx    <= '0;
            starve_cnt <= '0;
            init_done  <= 1'b0;
            dbg.ack    <= 1'b0;
            dbg.rdata  <= '0;
        end else begin
            dbg.ack <= 1'b0;
            unique case (state)
                INIT: begin
                    if (clr_idx == XZR) begin
                        clr_idx   <= '0;
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                IDLE: begin
                    // A starved request takes the port even if the CPU is writing.
                    if (dbg.req) begin
                        if (starve_full || !cpu_reg_write) begin
                            state <= DBG_SVC;
                        end else begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                DBG_SVC: begin
                    dbg.rdata <= (dbg.addr == XZR) ? '0 : rf_rdata1;
                    dbg.ack   <= 1'b1;
                    state     <= DBG_ACK;
                end
                DBG_ACK: begin
                    starve_cnt <= '0;
                    state      <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end

    always_comb begin
        rf_we     = 1'b0;
        rf_waddr  = cpu_write_reg;
        rf_wdata  = cpu_write_data;
        rf_raddr1 = cpu_read_reg1;
        cpu_stall = 1'b0;
        unique case (state)
            INIT: begin
                rf_we     = rst_n;
                rf_waddr  = clr_idx;
                rf_wdata  = '0;
                cpu_stall = 1'b1;
            end
            IDLE: begin
                // The relief cycle blocks the CPU write; the stalled CPU re-presents it.
                if (dbg.req && starve_full) begin
                    cpu_stall = 1'b1;
                end else begin
                    rf_we = cpu_reg_write && (cpu_write_reg != XZR);
                end
            end
            DBG_SVC: begin
                cpu_stall = 1'b1;
                rf_raddr1 = dbg.addr;
                rf_waddr  = dbg.addr;
                rf_wdata  = dbg.wdata;
                rf_we     = dbg.we && (dbg.addr != XZR);
            end
            DBG_ACK: begin
                rf_we = cpu_reg_write && (cpu_write_reg != XZR);
            end
            default: cpu_stall = 1'b1;
        endcase
    end

    assign cpu_read_data1 = (cpu_read_reg1 == XZR) ? '0 : rf_rdata1;

endmodule
